// File: rtl/game_move_sequencer.sv
// Move sequencer for the 2048 board: owns the board register, steers the candidate mux,
// spawns new tiles from a Galois LFSR and flags win/lose after every board update.
module game_move_sequencer #(
  parameter logic [11:0] WIN_VALUE = 12'd2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   load_en,
  input  logic [3:0][3:0][11:0]  load_board,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  input  logic [3:0][3:0][11:0]  moved_board,
  output logic [1:0]             mux_sel,
  output logic [3:0][3:0][11:0]  board,
  output logic                   busy,
  output logic                   move_done,
  output logic                   moved,
  output logic                   win,
  output logic                   lose
);

  typedef enum logic [2:0] {
    IDLE, READY, SELECT, COMPARE, COMMIT, SPAWN, CHECK, OVER
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [1:0]  dir;
  logic [3:0]  scan_idx;
  logic [3:0]  scan_cnt;
  logic [1:0]  spawn_left;
  logic        from_move;
  logic [11:0] scan_cell;
  logic        any_win;
  logic        any_zero;
  logic        any_pair;
  logic        lose_now;
  logic        idle_like;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign scan_cell = board[scan_idx[3:2]][scan_idx[1:0]];
  assign idle_like = (state == IDLE) || (state == READY) || (state == OVER);
  assign lose_now  = !any_win && !any_zero && !any_pair;

  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] == WIN_VALUE) any_win = 1'b1;
        if (board[r][c] == 12'd0) any_zero = 1'b1;
        if (c < 3 && board[r][c] == board[r][c+1]) any_pair = 1'b1;
        if (r < 3 && board[r][c] == board[r+1][c]) any_pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      board      <= '0;
      lfsr       <= LFSR_SEED;
      dir        <= 2'b00;
      mux_sel    <= 2'b00;
      scan_idx   <= 4'd0;
      scan_cnt   <= 4'd0;
      spawn_left <= 2'd0;
      from_move  <= 1'b0;
      busy       <= 1'b0;
      move_done  <= 1'b0;
      moved      <= 1'b0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      lfsr      <= lfsr_next;
      move_done <= 1'b0;
      if (start) begin
        board      <= '0;
        lfsr       <= LFSR_SEED;
        win        <= 1'b0;
        lose       <= 1'b0;
        scan_idx   <= LFSR_SEED[3:0];
        scan_cnt   <= 4'd0;
        spawn_left <= 2'd2;
        from_move  <= 1'b0;
        busy       <= 1'b1;
        state      <= SPAWN;
      end else if (load_en && idle_like) begin
        board     <= load_board;
        win       <= 1'b0;
        lose      <= 1'b0;
        from_move <= 1'b0;
        busy      <= 1'b1;
        state     <= CHECK;
      end else begin
        case (state)
          READY: begin
            if (move_valid) begin
              dir     <= move_dir;
              mux_sel <= {move_dir[0], move_dir[1]};
              busy    <= 1'b1;
              state   <= SELECT;
            end
          end
          SELECT: state <= COMPARE;
          COMPARE: begin
            if (moved_board == board) begin
              move_done <= 1'b1;
              moved     <= 1'b0;
              busy      <= 1'b0;
              state     <= READY;
            end else begin
              state <= COMMIT;
            end
          end
          COMMIT: begin
            board      <= moved_board;
            scan_idx   <= lfsr[3:0];
            scan_cnt   <= 4'd0;
            spawn_left <= 2'd1;
            from_move  <= 1'b1;
            state      <= SPAWN;
          end
          SPAWN: begin
            // A tile ends on the first empty cell or after a full lap of 16 cells.
            if (scan_cell == 12'd0 || scan_cnt == 4'd15) begin
              if (scan_cell == 12'd0)
                board[scan_idx[3:2]][scan_idx[1:0]] <= (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
              if (spawn_left == 2'd2) begin
                spawn_left <= 2'd1;
                scan_idx   <= lfsr[3:0];
                scan_cnt   <= 4'd0;
              end else begin
                state <= CHECK;
              end
            end else begin
              scan_idx <= scan_idx + 4'd1;
              scan_cnt <= scan_cnt + 4'd1;
            end
          end
          CHECK: begin
            win  <= any_win;
            lose <= lose_now;
            if (from_move) begin
              move_done <= 1'b1;
              moved     <= 1'b1;
            end
            busy  <= 1'b0;
            state <= (any_win || lose_now) ? OVER : READY;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_move_sequencer.sv
// Self-checking bench for game_move_sequencer: a real 2048 slide model feeds moved_board,
// and a spec-level spawn model predicts the board, latency and flags after each move.
module tb_game_move_sequencer;

  typedef logic [3:0][3:0][11:0] brd_t;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_dir = 2'b00;
  brd_t       load_board = '0;
  brd_t       moved_board;
  brd_t       board;
  logic [1:0] mux_sel;
  logic       busy, move_done, moved, win, lose;
  logic [15:0] m_lfsr;
  int         n_cmp = 0;
  int         n_bad = 0;

  game_move_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_board(load_board),
    .move_valid(move_valid), .move_dir(move_dir), .moved_board(moved_board),
    .mux_sel(mux_sel), .board(board), .busy(busy), .move_done(move_done),
    .moved(moved), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Free-running spawn LFSR as seen from the outside: reset/start reload the seed.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else if (start) m_lfsr <= SEED;
    else m_lfsr <= lfsr_step(m_lfsr);
  end

  // Slide one line toward element 0, merging each equal pair once.
  function automatic logic [3:0][11:0] slide_line(input logic [3:0][11:0] l);
    logic [11:0] q [4];
    logic [3:0][11:0] r;
    int n, m, i;
    r = '0; n = 0; m = 0; i = 0;
    for (int k = 0; k < 4; k++) begin
      q[k] = 12'd0;
    end
    for (int k = 0; k < 4; k++) begin
      if (l[k] != 12'd0) begin q[n] = l[k]; n++; end
    end
    while (i < n) begin
      if (i + 1 < n && q[i] == q[i+1]) begin r[m] = {q[i][10:0], 1'b0}; i += 2; end
      else begin r[m] = q[i]; i++; end
      m++;
    end
    return r;
  endfunction

  // Candidate board for direction d (00 up, 01 down, 10 left, 11 right).
  function automatic brd_t candidate(input brd_t b, input logic [1:0] d);
    brd_t r;
    logic [3:0][11:0] ln, o;
    r = b;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (d)
          2'b00: ln[j] = b[j][i];
          2'b01: ln[j] = b[3-j][i];
          2'b10: ln[j] = b[i][j];
          default: ln[j] = b[i][3-j];
        endcase
      end
      o = slide_line(ln);
      for (int j = 0; j < 4; j++) begin
        case (d)
          2'b00: r[j][i] = o[j];
          2'b01: r[3-j][i] = o[j];
          2'b10: r[i][j] = o[j];
          default: r[i][3-j] = o[j];
        endcase
      end
    end
    return r;
  endfunction

  always_comb moved_board = candidate(board, {mux_sel[0], mux_sel[1]});

  // Place `count` tiles: scan from s one cell per cycle, l is the LFSR value on the first scan cycle.
  function automatic void spawn_model(input brd_t b_in, input logic [3:0] s_in, input logic [15:0] l_in,
                                      input int count, output brd_t b_out, output int edges);
    brd_t b;
    logic [3:0] s, s_next, idx;
    logic [15:0] l;
    bit found;
    b = b_in; s = s_in; l = l_in; edges = 0; s_next = s_in;
    for (int t = 0; t < count; t++) begin
      found = 0;
      for (int k = 0; k < 16 && !found; k++) begin
        idx = s + k[3:0];
        if (b[idx[3:2]][idx[1:0]] == 12'd0) begin
          b[idx[3:2]][idx[1:0]] = (l[7:4] == 4'd0) ? 12'd4 : 12'd2;
          found = 1;
        end
        if (found || k == 15) s_next = l[3:0];
        l = lfsr_step(l);
        edges++;
      end
      s = s_next;
    end
    b_out = b;
  endfunction

  function automatic logic win_of(input brd_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == 12'd2048) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic lose_of(input brd_t b);
    if (win_of(b)) return 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r][c] == 12'd0) return 1'b0;
        if (c < 3 && b[r][c] == b[r][c+1]) return 1'b0;
        if (r < 3 && b[r][c] == b[r+1][c]) return 1'b0;
      end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Preload a board; returns at the negedge after the CHECK cycle.
  task automatic applyStimulus(input brd_t b);
    @(negedge clk);
    load_board = b;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    checkOutput("load_busy", 192'(busy), 192'(1'b0));
    checkOutput("load_win", 192'(win), 192'(win_of(b)));
    checkOutput("load_lose", 192'(lose), 192'(lose_of(b)));
  endtask

  // Issue one move from READY and check latency, board and flags against the model.
  task automatic checkMove(input string tag, input brd_t b, input logic [1:0] d, output brd_t exp_b);
    brd_t cand;
    logic [15:0] l0, l3, l4;
    int j, e, exp_j;
    logic exp_mv;
    cand = candidate(b, d);
    move_dir = d;
    move_valid = 1'b1;
    l0 = m_lfsr;
    @(negedge clk);
    move_valid = 1'b0;
    j = 0;
    while (move_done !== 1'b1 && j < 40) begin
      @(negedge clk);
      j++;
    end
    if (cand == b) begin
      exp_b = b; exp_j = 2; exp_mv = 1'b0;
    end else begin
      l3 = lfsr_step(lfsr_step(lfsr_step(l0)));
      l4 = lfsr_step(l3);
      spawn_model(cand, l3[3:0], l4, 1, exp_b, e);
      exp_j = 4 + e; exp_mv = 1'b1;
    end
    checkOutput({tag, "_latency"}, 192'(j), 192'(exp_j));
    checkOutput({tag, "_moved"}, 192'(moved), 192'(exp_mv));
    checkOutput({tag, "_board"}, board, exp_b);
    checkOutput({tag, "_win"}, 192'(win), 192'(win_of(exp_b)));
    checkOutput({tag, "_lose"}, 192'(lose), 192'(lose_of(exp_b)));
    @(negedge clk);
    checkOutput({tag, "_pulse_len"}, 192'(move_done), 192'(1'b0));
  endtask

  // Start a game and compare the two-tile board to the seeded spawn model.
  task automatic doStart(input string tag);
    brd_t exp_b;
    logic [15:0] s0;
    int j, e, nz;
    s0 = SEED;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (busy !== 1'b0 && j < 40) begin
      @(negedge clk);
      j++;
    end
    spawn_model('0, s0[3:0], s0, 2, exp_b, e);
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (board[r][c] != 12'd0) nz++;
    checkOutput({tag, "_busy"}, 192'(busy), 192'(1'b0));
    checkOutput({tag, "_board"}, board, exp_b);
    checkOutput({tag, "_tiles"}, 192'(nz), 192'(2));
    checkOutput({tag, "_win"}, 192'(win), 192'(1'b0));
    checkOutput({tag, "_lose"}, 192'(lose), 192'(1'b0));
  endtask

  initial begin
    brd_t b, exp_b;
    int pulses;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_board", board, '0);
    checkOutput("rst_flags", 192'({busy, move_done, moved, win, lose}), 192'(5'b0));
    checkOutput("rst_mux", 192'(mux_sel), 192'(2'b00));
    rst = 1'b0;
    @(negedge clk);

    doStart("start1");

    b = '0; b[0][0] = 12'd2; b[0][1] = 12'd2;
    applyStimulus(b);
    checkMove("left", b, 2'b10, exp_b);
    checkOutput("left_mux", 192'(mux_sel), 192'(2'b01));
    checkOutput("left_cell00", 192'(board[0][0]), 192'(12'd4));

    b = '0; b[0][0] = 12'd2;
    applyStimulus(b);
    checkMove("nochange", b, 2'b00, exp_b);

    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[r][c] = ($urandom_range(0, 2) == 0) ? 12'd0 : (12'd2 << $urandom_range(0, 5));
      b[$urandom_range(0, 3)][$urandom_range(0, 3)] = 12'd0;
      applyStimulus(b);
      checkMove($sformatf("rand%0d", it), b, 2'($urandom_range(0, 3)), exp_b);
    end

    b = '0; b[0][0] = 12'd1024; b[0][1] = 12'd1024;
    applyStimulus(b);
    checkMove("win", b, 2'b10, exp_b);
    checkOutput("win_flag", 192'(win), 192'(1'b1));
    move_dir = 2'b11;
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (move_done === 1'b1) pulses++;
    end
    checkOutput("over_pulses", 192'(pulses), 192'(0));
    checkOutput("over_board", board, exp_b);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
    applyStimulus(b);
    checkOutput("chk_lose", 192'(lose), 192'(1'b1));

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midspawn_board", board, '0);
    checkOutput("midspawn_flags", 192'({busy, move_done, moved, win, lose}), 192'(5'b0));
    checkOutput("midspawn_mux", 192'(mux_sel), 192'(2'b00));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    doStart("start2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_move_sequencer.md
Name: game_move_sequencer

Overview:
- Control block for the 2048 board datapath. It owns the 4x4 board register and drives the select of the 4:1 board-matrix mux that picks one of the four candidate move results.
- It sequences each move: select, compare, commit, spawn a new tile, check for win or lose.
- It sits between the input/debounce logic and the move-candidate logic. The move-candidate logic reads `board`; the display reads `board`, `win` and `lose`.

Parameters:
- WIN_VALUE, 12'd2048, tile value that sets `win`.
- LFSR_SEED, 16'hACE1, reset and start value of the 16-bit spawn LFSR; must be non-zero.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new game; level sampled each cycle.
- load_en  in  1  test/debug board preload.
- load_board  in  12x[3:0][3:0]  board to preload.
- move_valid  in  1  move request, sampled only in READY.
- move_dir  in  2  00 up, 01 down, 10 left, 11 right.
- moved_board  in  12x[3:0][3:0]  mux output OM (selected candidate board).
- mux_sel  out  2  mux select S.
- board  out  12x[3:0][3:0]  current board, registered.
- busy  out  1  high in every state except IDLE, READY and OVER.
- move_done  out  1  one-cycle pulse when a move finishes.
- moved  out  1  valid with `move_done`: 1 = board changed.
- win  out  1  sticky.
- lose  out  1  sticky.

Behaviour:
- Reset (async): all board cells 0, state IDLE, mux_sel 0, busy/move_done/moved/win/lose 0, LFSR = LFSR_SEED, latched direction 0.
- LFSR:
  - 16-bit Galois, mask 16'hB400, advances every cycle in every state.
  - `start` reloads it with LFSR_SEED, so spawn positions are deterministic.
- Priority each cycle: rst > start > load_en > move_valid.
- `start` (any state): clear the board, go to SPAWN with a spawn count of 2, then CHECK, then READY.
- `load_en` (IDLE/READY/OVER only; ignored while busy): board <= load_board, clear win/lose, go to CHECK with no `move_done` pulse.
- States:
  - IDLE: wait for `start` or `load_en`.
  - READY:
    - On `move_valid`, latch `move_dir` and go to SELECT.
    - `move_valid` in any other state is dropped, not queued.
  - SELECT:
    - mux_sel = {dir[0], dir[1]} so the mux returns candidate M<dir>.
    - Held from SELECT through COMPARE; 1 cycle for mux/move logic to settle.
  - COMPARE:
    - If moved_board == board: pulse move_done with moved=0, return to READY. No spawn; the LFSR keeps running.
    - Otherwise go to COMMIT.
  - COMMIT: board <= moved_board; scan index <= lfsr[3:0].
  - SPAWN:
    - One cell per cycle, flat index = row*4+col, starting at the scan index and incrementing mod 16.
    - At the first cell == 0, write 12'd4 if lfsr[7:4] == 0, else 12'd2.
    - If 16 cells are scanned with none empty, skip the write.
    - Max 16 cycles per tile. With spawn count 2, the second tile restarts the scan at the current lfsr[3:0].
  - CHECK (1 cycle), evaluated on the updated board:
    - win = any cell == WIN_VALUE.
    - lose = no zero cell AND no horizontally or vertically adjacent equal pair.
    - win takes precedence; lose is forced 0 when win is 1.
    - Pulse move_done with moved=1 if entered from a move.
    - Next state is OVER if win or lose, else READY.
  - OVER: board frozen, moves ignored; only `start`, `load_en` or rst leave it.
- Latency (move accepted at cycle T):
  - SELECT at T+1, COMPARE at T+2.
  - No-change: move_done at T+2.
  - Changed: COMMIT at T+3, spawn occupies T+4 up to T+19 at most, move_done 1 cycle after the spawn write.
- Cells hold literal values (0, 2, 4, ..., 2048); no arithmetic is done here.
- rst asserted mid-SPAWN or mid-COMMIT: immediate clear, no partial board survives.

Test Plan:
- Reset, then `start` → after at most 36 cycles, board has exactly two non-zero cells, each 2 or 4; busy=0; win=0; lose=0; the same positions on every run.
- Load row0 = {2,2,0,0}, others 0; move left; bench returns row0 = {4,0,0,0} when mux_sel==2'b01 → board[0][0]=4, exactly one new 2/4 tile in a previously zero cell, a single move_done with moved=1.
- Load any board; bench returns moved_board identical to board → move_done with moved=0 at T+2, board unchanged, no spawn.
- Move whose moved_board contains 2048 → win=1, lose=0, state OVER; a following move_valid is ignored and the board is unchanged.
- Load full checkerboard alternating 2/4 → CHECK sets lose=1, win=0, busy=0.
- Assert rst during SPAWN → all outputs 0 within the same cycle. `start` then produces the same two-tile board as the first scenario.
